// File: rtl/reg_write_queue.sv
// reg_write_queue
//   Small FIFO of pending register-file writes. Producers enqueue
//   (register, data) pairs; the register file drains the head entry.
//   Writes to register 0 complete the handshake but are never stored.
//   Optional forwarding lets two read ports see the newest pending
//   write to the register they are reading.
//
// Configuration macro:
//   REG_WQ_FORWARD_EN  - compile in the forward lookup; when undefined the
//                        fwd* outputs are tied to zero (ports remain).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              discard all pending entries next cycle
//   inValid/inReady    enqueue handshake; inReg/inData carry the write
//   outRegWrite        head entry present (register-file write enable)
//   outWriteRegister   head entry register address
//   outWriteData       head entry data
//   outAck             register file consumes the head this cycle
//   fwdReg1/2          read addresses checked against pending writes
//   fwdHit1/2          a pending write to that register exists
//   fwdData1/2         data of the newest matching pending write
//   count              number of stored entries
module reg_write_queue #(
  parameter int unsigned WordLen   = 32,
  parameter int unsigned WordCount = 16,
  parameter int unsigned Depth     = 4,
  localparam int unsigned AW = (WordCount > 1) ? $clog2(WordCount) : 1,
  localparam int unsigned PW = $clog2(Depth),
  localparam int unsigned CW = PW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               inValid,
  output logic               inReady,
  input  logic [AW-1:0]      inReg,
  input  logic [WordLen-1:0] inData,
  output logic               outRegWrite,
  output logic [AW-1:0]      outWriteRegister,
  output logic [WordLen-1:0] outWriteData,
  input  logic               outAck,
  input  logic [AW-1:0]      fwdReg1,
  input  logic [AW-1:0]      fwdReg2,
  output logic               fwdHit1,
  output logic               fwdHit2,
  output logic [WordLen-1:0] fwdData1,
  output logic [WordLen-1:0] fwdData2,
  output logic [CW-1:0]      count
);

  logic [AW-1:0]      r_reg  [Depth];
  logic [WordLen-1:0] r_data [Depth];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;

  logic w_accept;
  logic w_enq;
  logic w_deq;

  assign inReady  = (r_count < CW'(Depth));
  assign w_accept = inValid & inReady & ~flush;
  // Register 0 writes are acknowledged but dropped.
  assign w_enq    = w_accept & (inReg != '0);
  assign w_deq    = outRegWrite & outAck & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_reg[r_wptr]  <= inReg;
      r_data[r_wptr] <= inData;
    end
  end

  assign count            = r_count;
  assign outRegWrite      = (r_count != '0);
  // Gated so a drained queue presents zeros rather than stale slot contents.
  assign outWriteRegister = outRegWrite ? r_reg[r_rptr]  : '0;
  assign outWriteData     = outRegWrite ? r_data[r_rptr] : '0;

`ifdef REG_WQ_FORWARD_EN
  logic [PW-1:0] w_idx;

  // Walk live entries oldest to newest so the newest match overwrites.
  always_comb begin
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      w_idx = r_rptr + PW'(i);
      if (CW'(i) < r_count) begin
        if ((fwdReg1 != '0) && (r_reg[w_idx] == fwdReg1)) begin
          fwdHit1  = 1'b1;
          fwdData1 = r_data[w_idx];
        end
        if ((fwdReg2 != '0) && (r_reg[w_idx] == fwdReg2)) begin
          fwdHit2  = 1'b1;
          fwdData2 = r_data[w_idx];
        end
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwdReg1, fwdReg2};
  assign fwdHit1  = 1'b0;
  assign fwdHit2  = 1'b0;
  assign fwdData1 = '0;
  assign fwdData2 = '0;
`endif

endmodule
